// File: rtl/aoi_pkg.sv
// Shared definitions for the AOI cell family: vector count, checker state
// encoding and the golden AOI expression.
package aoi_pkg;

  localparam int AOI_NVEC = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic aoi_ref(input logic a, input logic b, input logic c, input logic d);
    return ~((a & b) | (c & d));
  endfunction

endpackage

// File: rtl/aoi.sv
// 4-input AND-OR-INVERT cell: o_y = ~((a & b) | (c & d)).
module aoi (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  input  logic i_d,
  output logic o_y
);

  assign o_y = ~((i_a & i_b) | (i_c & i_d));

endmodule

// File: rtl/aoi_resp_checker.sv
// Response checker for the AOI cell: compares observed y against a reference
// cell, tracks which of the 16 input vectors were exercised, reports pass/fail.
module aoi_resp_checker
  import aoi_pkg::*;
#(
  parameter int ERR_W       = 8,
  parameter int MAX_SAMPLES = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                vld,
  input  logic                a,
  input  logic                b,
  input  logic                c,
  input  logic                d,
  input  logic                y,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                cov_incomplete,
  output logic [ERR_W-1:0]    err_cnt,
  output logic [AOI_NVEC-1:0] cov_map,
  output logic [3:0]          first_fail_vec,
  output logic                first_fail_vld
);

  localparam int CNT_W = $clog2(MAX_SAMPLES + 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [ERR_W-1:0]    r_err;
  logic [AOI_NVEC-1:0] r_cov;
  logic [3:0]          r_ff_vec;
  logic                r_ff_vld;
  logic                r_cov_inc;

  logic                w_exp;
  logic                w_sample;
  logic                w_mis;
  logic                w_complete;
  logic                w_budget;
  logic [3:0]          w_idx;
  logic [AOI_NVEC-1:0] w_cov_upd;
  logic [CNT_W-1:0]    w_cnt_upd;

  aoi u_ref (
    .i_a (a),
    .i_b (b),
    .i_c (c),
    .i_d (d),
    .o_y (w_exp)
  );

  // A vld coinciding with start belongs to no run and is dropped.
  assign w_sample   = (r_state == RUN) && vld && !start;
  assign w_idx      = {a, b, c, d};
  assign w_mis      = (y != w_exp);
  assign w_cov_upd  = r_cov | (AOI_NVEC'(1) << w_idx);
  assign w_cnt_upd  = r_cnt + CNT_W'(1);
  assign w_complete = w_sample && (&w_cov_upd);
  assign w_budget   = w_sample && (w_cnt_upd == CNT_W'(MAX_SAMPLES));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_complete || w_budget) w_state_next = DONE;
      DONE:    if (start) w_state_next = RUN;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      r_cnt     <= '0;
      r_err     <= '0;
      r_cov     <= '0;
      r_ff_vec  <= '0;
      r_ff_vld  <= 1'b0;
      r_cov_inc <= 1'b0;
    end else if (w_sample) begin
      r_cnt <= w_cnt_upd;
      r_cov <= w_cov_upd;
      if (w_mis && (r_err != '1)) r_err <= r_err + ERR_W'(1);
      if (w_mis && !r_ff_vld) begin
        r_ff_vec <= w_idx;
        r_ff_vld <= 1'b1;
      end
      // Completion on the same sample as budget exhaustion counts as complete.
      if (w_budget && !w_complete) r_cov_inc <= 1'b1;
    end
  end

  always_comb begin
    busy           = (r_state == RUN);
    done           = (r_state == DONE);
    pass           = (r_state == DONE) && (r_err == '0) && !r_cov_inc;
    cov_incomplete = r_cov_inc;
    err_cnt        = r_err;
    cov_map        = r_cov;
    first_fail_vec = r_ff_vec;
    first_fail_vld = r_ff_vld;
  end

`ifndef SYNTHESIS
  ref_agrees: assert property (@(posedge clk) w_exp == aoi_ref(a, b, c, d));
`endif

endmodule

// File: tb/tb_aoi_resp_checker.sv
// Bench for aoi_resp_checker: three instances (default, MAX_SAMPLES=20, ERR_W=2)
// share one stimulus stream and are checked against a per-instance model.
module tb_aoi_resp_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic vld = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic y = 1'b1;

  always #5 clk = ~clk;

  logic        busy_v[3], done_v[3], pass_v[3], inc_v[3], ffvld_v[3];
  logic [15:0] cov_v[3];
  logic [3:0]  ffvec_v[3];
  logic [7:0]  err0, err1;
  logic [1:0]  err2;

  aoi_resp_checker #(.ERR_W(8), .MAX_SAMPLES(64)) dut_def (
    .clk(clk), .rst_n(rst_n), .start(start), .vld(vld),
    .a(a), .b(b), .c(c), .d(d), .y(y),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .cov_incomplete(inc_v[0]),
    .err_cnt(err0), .cov_map(cov_v[0]), .first_fail_vec(ffvec_v[0]), .first_fail_vld(ffvld_v[0])
  );

  aoi_resp_checker #(.ERR_W(8), .MAX_SAMPLES(20)) dut_bud (
    .clk(clk), .rst_n(rst_n), .start(start), .vld(vld),
    .a(a), .b(b), .c(c), .d(d), .y(y),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .cov_incomplete(inc_v[1]),
    .err_cnt(err1), .cov_map(cov_v[1]), .first_fail_vec(ffvec_v[1]), .first_fail_vld(ffvld_v[1])
  );

  aoi_resp_checker #(.ERR_W(2), .MAX_SAMPLES(64)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .vld(vld),
    .a(a), .b(b), .c(c), .d(d), .y(y),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .cov_incomplete(inc_v[2]),
    .err_cnt(err2), .cov_map(cov_v[2]), .first_fail_vec(ffvec_v[2]), .first_fail_vld(ffvld_v[2])
  );

  typedef struct {
    bit        running;
    bit        finished;
    bit        ffvld;
    bit        inc;
    int        errs;
    int        n;
    int        ffv;
    bit [15:0] cov;
  } model_t;

  model_t m[3];
  int max_s[3]   = '{64, 20, 64};
  int err_max[3] = '{255, 255, 3};
  int n_checks = 0;
  int n_fail   = 0;

  function automatic bit golden(input bit [3:0] v);
    return !((v[3] && v[2]) || (v[1] && v[0]));
  endfunction

  function automatic logic [7:0] err_of(input int i);
    case (i)
      0:       return err0;
      1:       return err1;
      default: return {6'b0, err2};
    endcase
  endfunction

  // {busy, done, pass, cov_incomplete, first_fail_vld, first_fail_vec, cov_map, err_cnt}
  function automatic logic [32:0] snap(input int i);
    return {busy_v[i], done_v[i], pass_v[i], inc_v[i], ffvld_v[i], ffvec_v[i], cov_v[i], err_of(i)};
  endfunction

  function automatic logic [32:0] msnap(input int i);
    bit p;
    p = m[i].finished && (m[i].errs == 0) && !m[i].inc;
    return {m[i].running, m[i].finished, p, m[i].inc, m[i].ffvld, 4'(m[i].ffv), m[i].cov, 8'(m[i].errs)};
  endfunction

  // One clock: drive inputs, let the edge happen, settle 1ns, advance the models.
  task automatic step(input bit st, input bit v, input bit [3:0] vec, input bit wrong);
    start = st;
    vld   = v;
    {a, b, c, d} = vec;
    y = golden(vec) ^ wrong;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m[i] = '{default: 0};
      end else if (st) begin
        m[i] = '{default: 0};
        m[i].running = 1'b1;
      end else if (v && m[i].running) begin
        if (wrong) begin
          if (m[i].errs < err_max[i]) m[i].errs++;
          if (!m[i].ffvld) begin
            m[i].ffvld = 1'b1;
            m[i].ffv   = int'(vec);
          end
        end
        m[i].cov[vec] = 1'b1;
        m[i].n++;
        if (m[i].cov == 16'hFFFF) begin
          m[i].running  = 1'b0;
          m[i].finished = 1'b1;
        end else if (m[i].n == max_s[i]) begin
          m[i].running  = 1'b0;
          m[i].finished = 1'b1;
          m[i].inc      = 1'b1;
        end
      end
    end
    start = 1'b0;
    vld   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 4'hF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (snap(i) !== 33'h0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: got %h want 0", i, snap(i));
      end
    end
    rst_n = 1'b1;
    step(1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic test_idle_gating();
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'b1);
    n_checks++;
    if (cov_v[0] !== 16'h0 || err0 !== 8'h0 || busy_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_gating: got cov=%h err=%0d busy=%b want 0/0/0", cov_v[0], err0, busy_v[0]);
    end
  endtask

  task automatic test_clean_sweep();
    step(1'b1, 1'b0, 4'h0, 1'b0);
    n_checks++;
    if (busy_v[0] !== 1'b1 || err0 !== 8'h0) begin
      n_fail++;
      $display("FAIL start_busy: got busy=%b err=%0d want 1/0", busy_v[0], err0);
    end
    for (int v = 0; v < 16; v++) begin
      step(1'b0, 1'b1, 4'(v), 1'b0);
      if (v == 14) begin
        n_checks++;
        if (done_v[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL sweep_early_done: got %b want 0", done_v[0]);
        end
      end
    end
    n_checks++;
    if (done_v[0] !== 1'b1 || pass_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_done: got done=%b pass=%b busy=%b want 1/1/0", done_v[0], pass_v[0], busy_v[0]);
    end
    n_checks++;
    if (err0 !== 8'h0 || cov_v[0] !== 16'hFFFF || ffvld_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_state: got err=%0d cov=%h ffvld=%b want 0/ffff/0", err0, cov_v[0], ffvld_v[0]);
    end
  endtask

  task automatic test_done_gating();
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 4'(k), 1'b1);
    n_checks++;
    if (cov_v[0] !== 16'hFFFF || err0 !== 8'h0 || done_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL done_gating: got cov=%h err=%0d done=%b want ffff/0/1", cov_v[0], err0, done_v[0]);
    end
  endtask

  task automatic test_faults();
    step(1'b1, 1'b0, 4'h0, 1'b0);
    for (int v = 0; v < 16; v++) step(1'b0, 1'b1, 4'(v), (v == 5) || (v == 12));
    n_checks++;
    if (err0 !== 8'd2 || ffvec_v[0] !== 4'd5 || ffvld_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL faults_capture: got err=%0d ffvec=%0d ffvld=%b want 2/5/1", err0, ffvec_v[0], ffvld_v[0]);
    end
    n_checks++;
    if (done_v[0] !== 1'b1 || pass_v[0] !== 1'b0 || inc_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL faults_verdict: got done=%b pass=%b inc=%b want 1/0/0", done_v[0], pass_v[0], inc_v[0]);
    end
  endtask

  task automatic test_budget();
    step(1'b1, 1'b0, 4'h0, 1'b0);
    for (int v = 0; v < 15; v++) step(1'b0, 1'b1, 4'(v), 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 4'd3, 1'b0);
      if (k == 3) begin
        n_checks++;
        if (done_v[1] !== 1'b0) begin
          n_fail++;
          $display("FAIL budget_early_done: got %b want 0", done_v[1]);
        end
      end
    end
    n_checks++;
    if (done_v[1] !== 1'b1 || inc_v[1] !== 1'b1 || pass_v[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL budget_verdict: got done=%b inc=%b pass=%b want 1/1/0", done_v[1], inc_v[1], pass_v[1]);
    end
    n_checks++;
    if (cov_v[1] !== 16'h7FFF || busy_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL budget_cov: got cov=%h busy_def=%b want 7fff/1", cov_v[1], busy_v[0]);
    end
  endtask

  task automatic test_saturation();
    step(1'b1, 1'b0, 4'h0, 1'b0);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 4'd0, 1'b1);
    for (int v = 1; v < 16; v++) step(1'b0, 1'b1, 4'(v), 1'b0);
    n_checks++;
    if (err2 !== 2'd3 || pass_v[2] !== 1'b0 || done_v[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL saturation: got err=%0d pass=%b done=%b want 3/0/1", err2, pass_v[2], done_v[2]);
    end
    n_checks++;
    if (err0 !== 8'd10) begin
      n_fail++;
      $display("FAIL saturation_wide: got err=%0d want 10", err0);
    end
  endtask

  task automatic test_restart();
    step(1'b1, 1'b0, 4'h0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 4'(k + 4), 1'b1);
    step(1'b1, 1'b1, 4'd7, 1'b1);
    n_checks++;
    if (err0 !== 8'h0 || cov_v[0] !== 16'h0 || busy_v[0] !== 1'b1 || ffvld_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_clear: got err=%0d cov=%h busy=%b ffvld=%b want 0/0/1/0", err0, cov_v[0], busy_v[0], ffvld_v[0]);
    end
    for (int v = 0; v < 16; v++) step(1'b0, 1'b1, 4'(v), 1'b0);
    n_checks++;
    if (err0 !== 8'h0 || pass_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_pass: got err=%0d pass=%b want 0/1", err0, pass_v[0]);
    end
  endtask

  task automatic test_reset_midrun();
    step(1'b1, 1'b0, 4'h0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 4'(k), 1'b1);
    rst_n = 1'b0;
    step(1'b1, 1'b1, 4'd9, 1'b1);
    rst_n = 1'b1;
    n_checks++;
    if (snap(0) !== 33'h0) begin
      n_fail++;
      $display("FAIL reset_midrun: got %h want 0", snap(0));
    end
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 4'(k + 8), 1'b1);
    n_checks++;
    if (cov_v[0] !== 16'h0 || err0 !== 8'h0 || busy_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_then_idle: got cov=%h err=%0d busy=%b want 0/0/0", cov_v[0], err0, busy_v[0]);
    end
  endtask

  task automatic test_random();
    bit st, v, w;
    bit [3:0] vec;
    step(1'b1, 1'b0, 4'h0, 1'b0);
    for (int cyc = 0; cyc < 400; cyc++) begin
      st  = ($urandom_range(0, 39) == 0);
      v   = ($urandom_range(0, 3) != 0);
      vec = 4'($urandom_range(0, 15));
      w   = ($urandom_range(0, 7) == 0);
      step(st, v, vec, w);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (snap(i) !== msnap(i)) begin
          n_fail++;
          $display("FAIL random[%0d] cyc %0d: got %h want %h", i, cyc, snap(i), msnap(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_gating();
    test_clean_sweep();
    test_done_gating();
    test_faults();
    test_budget();
    test_saturation();
    test_restart();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
